// File: rtl/frame_dump_ctrl_pkg.sv
// Shared encodings and constants for the frame buffer UART dump sequencer.
package frame_dump_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_HDR   = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARM   = ST_ARM,
    FETCH = ST_FETCH,
    LATCH = ST_LATCH,
    SEND  = ST_SEND,
    NEXT  = ST_NEXT,
    DONE  = ST_DONE,
    HDR   = ST_HDR
  } state_t;

  localparam logic [7:0] HDR_BYTE0      = 8'hA5;
  localparam logic [7:0] HDR_BYTE1      = 8'h5A;
  localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/frame_dump_ctrl_if.sv
// Buffer read port plus UART byte write port, seen from the dump sequencer.
interface frame_dump_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 5
);
  logic [XW-1:0] rd_x_o;
  logic [YW-1:0] rd_y_o;
  logic [31:0]   rd_data_i;
  logic          uart_busy_i;
  logic          uart_wr_o;
  logic [7:0]    uart_dat_o;

  modport master (
    output rd_x_o, rd_y_o, uart_wr_o, uart_dat_o,
    input  rd_data_i, uart_busy_i
  );

  modport slave (
    input  rd_x_o, rd_y_o, uart_wr_o, uart_dat_o,
    output rd_data_i, uart_busy_i
  );
endinterface

// File: rtl/frame_dump_ctrl_uart_holdoff.sv
// Saturating idle-gap counter: ready once the UART has been quiet for 2**HOLDOFF_W-1 cycles.
module uart_holdoff #(
  parameter int HOLDOFF_W = 13
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic busy,
  output logic ready
);
  logic [HOLDOFF_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (clear || busy)  cnt <= '0;
    else if (!(&cnt))        cnt <= cnt + HOLDOFF_W'(1);
  end

  assign ready = &cnt;
endmodule

// File: rtl/frame_dump_ctrl.sv
// Frame buffer -> UART dump sequencer. Optional 3-byte header per dump with FRAME_DUMP_HEADER_EN.
module frame_dump_ctrl
  import frame_dump_ctrl_pkg::*;
#(
  parameter int WIDTH        = 40,
  parameter int HEIGHT       = 30,
  parameter int XW           = 6,
  parameter int YW           = 5,
  parameter int HOLDOFF_W    = 13,
  parameter int AUTO_RESTART = 1
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_n_i,
  input  logic              start_i,
  input  logic              frame_sync_i,
  frame_dump_ctrl_if.master bus,
  output logic              busy_o,
  output logic              done_o
);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [1:0]    Z_LAST = 2'(BYTES_PER_WORD - 1);

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    z;
  logic [31:0]   word_q;
  logic [7:0]    frame_cnt;
  logic [7:0]    tx_byte;
  logic          ho_ready;
  logic          fire;

  // Clearing on the decision cycle gives exactly 2**HOLDOFF_W cycles between strobes.
  uart_holdoff #(.HOLDOFF_W(HOLDOFF_W)) u_holdoff (
    .clk   (sys_clk_i),
    .rst_n (sys_rst_n_i),
    .clear (fire),
    .busy  (bus.uart_busy_i),
    .ready (ho_ready)
  );

  assign fire = ho_ready && !bus.uart_busy_i && !bus.uart_wr_o &&
                ((state == SEND) || (state == HDR));

  assign bus.rd_x_o = x;
  assign bus.rd_y_o = y;

  always_comb begin
    tx_byte = 8'h00;
    case (z)
      2'd0:    tx_byte = word_q[31:24];
      2'd1:    tx_byte = word_q[23:16];
      2'd2:    tx_byte = word_q[15:8];
      default: tx_byte = word_q[7:0];
    endcase
`ifdef FRAME_DUMP_HEADER_EN
    if (state == HDR) begin
      case (z)
        2'd0:    tx_byte = HDR_BYTE0;
        2'd1:    tx_byte = HDR_BYTE1;
        default: tx_byte = frame_cnt;
      endcase
    end
`endif
  end

`ifndef FRAME_DUMP_HEADER_EN
  logic unused_frame_cnt;
  assign unused_frame_cnt = ^frame_cnt;
`endif

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      z              <= '0;
      word_q         <= '0;
      frame_cnt      <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      bus.uart_wr_o  <= 1'b0;
      bus.uart_dat_o <= '0;
    end else begin
      bus.uart_wr_o <= 1'b0;
      done_o        <= 1'b0;
      if (fire) begin
        bus.uart_wr_o  <= 1'b1;
        bus.uart_dat_o <= tx_byte;
      end
      unique case (state)
        IDLE: if (start_i) begin
          state  <= ARM;
          busy_o <= 1'b1;
        end
        ARM: if (frame_sync_i) begin
          z <= '0;
`ifdef FRAME_DUMP_HEADER_EN
          state <= HDR;
`else
          state <= FETCH;
`endif
        end
`ifdef FRAME_DUMP_HEADER_EN
        HDR: if (fire) begin
          if (z == 2'd2) begin
            z     <= '0;
            state <= FETCH;
          end else begin
            z <= z + 2'd1;
          end
        end
`endif
        FETCH: state <= LATCH;
        LATCH: begin
          word_q <= bus.rd_data_i;
          z      <= '0;
          state  <= SEND;
        end
        SEND: if (fire) begin
          if (z == Z_LAST) state <= NEXT;
          else             z     <= z + 2'd1;
        end
        NEXT: begin
          if (x == X_LAST) begin
            if (y == Y_LAST) begin
              state <= DONE;
            end else begin
              x     <= '0;
              y     <= y + YW'(1);
              state <= FETCH;
            end
          end else begin
            x     <= x + XW'(1);
            state <= FETCH;
          end
        end
        DONE: begin
          done_o    <= 1'b1;
          frame_cnt <= frame_cnt + 8'd1;
          x         <= '0;
          y         <= '0;
          if (AUTO_RESTART != 0) begin
            state <= ARM;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Scoreboard bench for frame_dump_ctrl on a reduced 5x3 buffer; honours FRAME_DUMP_HEADER_EN.
module tb_frame_dump_ctrl;
  localparam int W  = 5;
  localparam int H  = 3;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int HW = 4;
  localparam int GAP = 16;
`ifdef FRAME_DUMP_HEADER_EN
  localparam int HDR_N = 3;
`else
  localparam int HDR_N = 0;
`endif
  localparam int DUMP_BYTES = W * H * 4 + HDR_N;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic sync = 1'b0;
  logic busy, done;

  frame_dump_ctrl_if #(.XW(XW), .YW(YW)) bus ();

  frame_dump_ctrl #(
    .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .HOLDOFF_W(HW), .AUTO_RESTART(1)
  ) dut (
    .sys_clk_i    (clk),
    .sys_rst_n_i  (rst_n),
    .start_i      (start),
    .frame_sync_i (sync),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  // Buffer model: one-cycle registered read of {y, x, 00, C3}.
  always @(posedge clk) bus.rd_data_i <= {8'(bus.rd_y_o), 8'(bus.rd_x_o), 8'h00, 8'hC3};

  // UART model: busy for 10 cycles after each write strobe.
  int bcnt = 0;
  bit busy_en = 1'b1;
  always @(posedge clk) begin
    if (bus.uart_wr_o)  bcnt <= 10;
    else if (bcnt > 0)  bcnt <= bcnt - 1;
  end
  assign bus.uart_busy_i = busy_en && (bcnt != 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int wr_total = 0;
  int wr_in_dump = 0;
  int done_cnt = 0;
  int last_wr = 0;
  bit gap_chk = 1'b0;
  bit prev_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_dump(input logic [7:0] fc);
`ifdef FRAME_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(fc);
`else
    if (fc == 8'hFF) exp_q.push_back(8'hEE);
`endif
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        exp_q.push_back(8'(yy));
        exp_q.push_back(8'(xx));
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hC3);
      end
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      tick();
      n++;
    end
  endtask

  // Monitor: every write strobe pops one expected byte.
  always @(negedge clk) begin
    if (bus.uart_wr_o) begin
      wr_total++;
      chk("no_back_to_back", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_write", 32'(bus.uart_dat_o), 32'h100);
      else                   chk($sformatf("byte%0d", wr_in_dump), 32'(bus.uart_dat_o), 32'(exp_q.pop_front()));
      if (gap_chk && wr_in_dump > 0) chk("write_gap", 32'(cyc - last_wr), 32'(GAP));
      last_wr = cyc;
      wr_in_dump++;
    end
    prev_wr = bus.uart_wr_o;
    if (done) done_cnt++;
  end

  initial begin
    int snap;
    int n;
    tick(3);
    chk("rst_wr",   32'(bus.uart_wr_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_x",    32'(bus.rd_x_o), 0);
    chk("rst_y",    32'(bus.rd_y_o), 0);
    chk("rst_dat",  32'(bus.uart_dat_o), 0);
    rst_n = 1'b1;
    tick(2);

    // Sync coincident with start must not trigger a dump.
    start = 1'b1;
    sync  = 1'b1;
    tick();
    start = 1'b0;
    sync  = 1'b0;
    tick(40);
    chk("gate_no_write", 32'(wr_total), 0);
    chk("gate_armed",    32'(busy), 1);

    // First dump with busy-holding UART; stray start mid-dump.
    push_dump(8'h00);
    wr_in_dump = 0;
    pulse_sync();
    n = 0;
    while (wr_total < 10 && n < 2000) begin tick(); n++; end
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1, 4000);
    chk("dump1_done_cnt", 32'(done_cnt), 1);
    chk("dump1_bytes",    32'(wr_in_dump), 32'(DUMP_BYTES));
    chk("dump1_q_empty",  32'(exp_q.size()), 0);
    tick(5);
    chk("rearm_busy", 32'(busy), 1);
    snap = wr_total;
    tick(30);
    chk("rearm_no_write", 32'(wr_total), 32'(snap));

    // Second dump with busy held low: fixed holdoff spacing.
    busy_en = 1'b0;
    gap_chk = 1'b1;
    push_dump(8'h01);
    wr_in_dump = 0;
    pulse_sync();
    wait_done(2, 3000);
    gap_chk = 1'b0;
    chk("dump2_done_cnt", 32'(done_cnt), 2);
    chk("dump2_bytes",    32'(wr_in_dump), 32'(DUMP_BYTES));
    chk("dump2_q_empty",  32'(exp_q.size()), 0);

    // Reset in the middle of a byte wait.
    busy_en = 1'b1;
    push_dump(8'h02);
    wr_in_dump = 0;
    pulse_sync();
    n = 0;
    while (wr_in_dump < 6 && n < 2000) begin tick(); n++; end
    chk("dump3_started", 32'(wr_in_dump >= 6), 1);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wr",   32'(bus.uart_wr_o), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_x",    32'(bus.rd_x_o), 0);
    chk("async_rst_y",    32'(bus.rd_y_o), 0);
    exp_q.delete();
    snap = wr_total;
    tick();
    rst_n = 1'b1;
    tick(100);
    chk("post_rst_no_write", 32'(wr_total), 32'(snap));
    chk("post_rst_idle",     32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
